// File: rtl/controller_pkg.sv
// Shared encodings for the pipelined MIPS controller: opcodes, functs, ALU codes
// and the layout of the control vectors carried down the pipe.
package controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // E vector: {valid, regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol}
    localparam int E_FLAG_W = 6;
    // Memory-side vector: {valid, regwrite, memtoreg, memwrite}
    localparam int M_W      = 4;
    localparam int MB_VALID = 3;
    localparam int MB_RW    = 2;
    localparam int MB_MTR   = 1;
    localparam int MB_MW    = 0;

    function automatic int e_bundle_w(input int aluctrl_w);
        return E_FLAG_W + aluctrl_w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: async active-low reset, sync clear beats enable.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/controller_pipe_gen.sv
// MIPS pipeline controller: combinational decode in D, control bits carried
// through E and a configurable memory-side register chain, plus retire counter.
module controller_pipe_gen
    import controller_pkg::*;
#(
    parameter int MEM_STAGES = 1,
    parameter int ALUCTRL_W  = 3,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 equalD,
    input  logic                 stallE,
    input  logic                 flushE,
    output logic                 pcsrcD,
    output logic                 jumpD,
    output logic                 branchD,
    output logic                 illegalD,
    output logic                 alusrcE,
    output logic                 regdstE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 regwriteE,
    output logic                 memtoregE,
    output logic                 validE,
    output logic                 memwriteM,
    output logic                 regwriteM,
    output logic                 memtoregM,
    output logic                 validM,
    output logic                 regwriteW,
    output logic                 memtoregW,
    output logic                 validW,
    output logic [CNT_W-1:0]     retire_count
);

    localparam int E_W = e_bundle_w(ALUCTRL_W);

    if (MEM_STAGES < 1 || MEM_STAGES > 4) begin : g_bad_mem_stages
        $error("controller_pipe_gen: MEM_STAGES must be in 1..4");
    end
    if (ALUCTRL_W < 3) begin : g_bad_aluctrl_w
        $error("controller_pipe_gen: ALUCTRL_W must be >= 3");
    end

    logic   regwrite_d, regdst_d, alusrc_d, memtoreg_d, memwrite_d;
    logic   beq_d, bne_d, jump_d, op_ok, funct_ok, ok_d;
    aluop_t aluop_d;
    logic [2:0] alu3_d;

    always_comb begin
        regwrite_d = 1'b0;
        regdst_d   = 1'b0;
        alusrc_d   = 1'b0;
        memtoreg_d = 1'b0;
        memwrite_d = 1'b0;
        beq_d      = 1'b0;
        bne_d      = 1'b0;
        jump_d     = 1'b0;
        aluop_d    = ALUOP_ADD;
        op_ok      = 1'b1;
        case (op)
            OP_RTYPE: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluop_d = ALUOP_FUNCT; end
            OP_LW:    begin regwrite_d = 1'b1; alusrc_d = 1'b1; memtoreg_d = 1'b1; end
            OP_SW:    begin memwrite_d = 1'b1; alusrc_d = 1'b1; end
            OP_BEQ:   begin beq_d = 1'b1; aluop_d = ALUOP_SUB; end
            OP_BNE:   begin bne_d = 1'b1; aluop_d = ALUOP_SUB; end
            OP_ADDI:  begin regwrite_d = 1'b1; alusrc_d = 1'b1; end
            OP_J:     jump_d = 1'b1;
            default:  op_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu3_d   = ALU_ADD;
        funct_ok = 1'b1;
        case (aluop_d)
            ALUOP_ADD: alu3_d = ALU_ADD;
            ALUOP_SUB: alu3_d = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  alu3_d = ALU_ADD;
                    FN_SUB:  alu3_d = ALU_SUB;
                    FN_AND:  alu3_d = ALU_AND;
                    FN_OR:   alu3_d = ALU_OR;
                    FN_SLT:  alu3_d = ALU_SLT;
                    default: begin alu3_d = 3'b000; funct_ok = 1'b0; end
                endcase
            end
        endcase
    end

    // Any illegal encoding squashes every control bit so it travels as a bubble.
    assign ok_d     = op_ok & funct_ok;
    assign illegalD = ~ok_d;
    assign branchD  = (beq_d | bne_d) & ok_d;
    assign jumpD    = jump_d & ok_d;
    assign pcsrcD   = ((beq_d & equalD) | (bne_d & ~equalD)) & ok_d;

    logic [E_W-1:0] e_d, e_q;

    assign e_d = ok_d ? {1'b1, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
                         ALUCTRL_W'(alu3_d)}
                      : '0;

    pipe_stage_reg #(.W(E_W)) u_e_stage (
        .clk   (clk),
        .rst_n (reset),
        .en    (~stallE),
        .clr   (flushE),
        .d     (e_d),
        .q     (e_q)
    );

    assign validE      = e_q[E_W-1];
    assign regwriteE   = e_q[E_W-2];
    assign memtoregE   = e_q[E_W-3];
    assign alusrcE     = e_q[E_W-5];
    assign regdstE     = e_q[E_W-6];
    assign alucontrolE = e_q[ALUCTRL_W-1:0];

    logic [M_W-1:0] m_q [MEM_STAGES];

    for (genvar gi = 0; gi < MEM_STAGES; gi++) begin : g_mem
        logic [M_W-1:0] stage_d;
        logic           stage_clr;
        // A stalled E must not duplicate into M, so the first stage takes a bubble.
        if (gi == 0) begin : g_first
            assign stage_d   = e_q[E_W-1 -: M_W];
            assign stage_clr = stallE;
        end else begin : g_rest
            assign stage_d   = m_q[gi-1];
            assign stage_clr = 1'b0;
        end
        pipe_stage_reg #(.W(M_W)) u_stage (
            .clk   (clk),
            .rst_n (reset),
            .en    (1'b1),
            .clr   (stage_clr),
            .d     (stage_d),
            .q     (m_q[gi])
        );
    end

    assign validM    = m_q[0][MB_VALID];
    assign regwriteM = m_q[0][MB_RW];
    assign memtoregM = m_q[0][MB_MTR];
    assign memwriteM = m_q[0][MB_MW];
    assign validW    = m_q[MEM_STAGES-1][MB_VALID];
    assign regwriteW = m_q[MEM_STAGES-1][MB_RW];
    assign memtoregW = m_q[MEM_STAGES-1][MB_MTR];

    logic [CNT_W-1:0] retire_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retire_reg <= '0;
        else if (validW)
            retire_reg <= retire_reg + CNT_W'(1);
    end

    assign retire_count = retire_reg;

endmodule
